// File: rtl/led_pwm_ctrl_if.sv
// Config write port for led_pwm_ctrl: valid/ready handshake into the shadow registers,
// plus a one-cycle error pulse when an accepted write names a channel that does not exist.
interface led_pwm_ctrl_if #(
   parameter int PWM_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [2:0]       cfg_ch;
   logic [1:0]       cfg_mode;
   logic [PWM_W-1:0] cfg_duty;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_mode, cfg_duty,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_mode, cfg_duty,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/led_pwm_ctrl.sv
// N-channel LED PWM (off/steady/blink/breathe); settings double-buffered, applied at period boundaries.
// pwm_out lags pwm_cnt/eff by one cycle; cfg_ready is held high after reset, so writes never stall.
module led_pwm_ctrl #(
   parameter int                NUM_CH        = 3,
   parameter int                PWM_W         = 8,
   parameter int                PRESCALE      = 187,
   parameter int                BLINK_PERIODS = 250,
   parameter logic [NUM_CH-1:0] OUT_INVERT    = '0
) (
   input  logic              clk_48mhz,
   input  logic              reset_n,
   led_pwm_ctrl_if.slave     cfg,
   output logic              period_start,
   output logic [NUM_CH-1:0] pwm_out
);
   localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE);
   localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_PERIODS - 1);
   localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_STEADY  = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   typedef struct packed {
      logic [1:0]       mode;
      logic [PWM_W-1:0] duty;
   } ch_cfg_t;

   logic [PRE_W-1:0] pre_cnt;
   logic [PWM_W-1:0] pwm_cnt;
   logic [BLK_W-1:0] blk_cnt;
   logic             blink_phase;
   logic             tick;
   logic             boundary;
   logic             cfg_ready_q;
   logic             cfg_err_q;
   logic             accept;
   logic             ch_ok;

   ch_cfg_t          shadow  [NUM_CH];
   ch_cfg_t          active  [NUM_CH];
   logic [PWM_W-1:0] ramp    [NUM_CH];
   logic [PWM_W-1:0] eff     [NUM_CH];
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] ramp_dn;

   assign tick          = (pre_cnt == PRE_MAX);
   assign boundary      = tick && (&pwm_cnt);
   assign accept        = cfg.cfg_valid && cfg_ready_q;
   assign ch_ok         = ({1'b0, cfg.cfg_ch} < NUM_CH_L);
   assign cfg.cfg_ready = cfg_ready_q;
   assign cfg.cfg_err   = cfg_err_q;

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt      <= '0;
         pwm_cnt      <= '0;
         blk_cnt      <= '0;
         blink_phase  <= 1'b0;
         period_start <= 1'b0;
         cfg_ready_q  <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         cfg_ready_q  <= 1'b1;
         cfg_err_q    <= accept && !ch_ok;
         period_start <= boundary;
         pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
         if (boundary) begin
            if (blk_cnt == BLK_MAX) begin
               blk_cnt     <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blk_cnt <= blk_cnt + 1'b1;
            end
         end
      end
   end

   // A write in the boundary cycle sets pending after the old flag was consumed, so it waits a period.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         ramp_dn <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            shadow[c] <= '0;
            active[c] <= '0;
            ramp[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (boundary && pending[c]) begin
               active[c]  <= shadow[c];
               pending[c] <= 1'b0;
               ramp[c]    <= '0;
               ramp_dn[c] <= 1'b0;
            end else if (boundary && (active[c].mode == MODE_BREATHE) && (active[c].duty != '0)) begin
               if (!ramp_dn[c]) begin
                  ramp[c] <= ramp[c] + 1'b1;
                  if ((ramp[c] + 1'b1) == active[c].duty) begin
                     ramp_dn[c] <= 1'b1;
                  end
               end else begin
                  ramp[c] <= ramp[c] - 1'b1;
                  if (ramp[c] == 1) begin
                     ramp_dn[c] <= 1'b0;
                  end
               end
            end
            if (accept && ch_ok && (cfg.cfg_ch == 3'(c))) begin
               shadow[c]  <= {cfg.cfg_mode, cfg.cfg_duty};
               pending[c] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         eff[c] = '0;
         case (active[c].mode)
            MODE_OFF:     eff[c] = '0;
            MODE_STEADY:  eff[c] = active[c].duty;
            MODE_BLINK:   eff[c] = blink_phase ? '0 : active[c].duty;
            MODE_BREATHE: eff[c] = ramp[c];
            default:      eff[c] = '0;
         endcase
      end
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         pwm_out <= OUT_INVERT;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            pwm_out[c] <= (pwm_cnt < eff[c]) ^ OUT_INVERT[c];
         end
      end
   end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: per-period active-tick counts compared against a period-level model
// (write log + blink/triangle-wave arithmetic), with PRESCALE=0 so one tick per clock.
module tb_led_pwm_ctrl;
   localparam int         NUM_CH = 3;
   localparam int         PWM_W  = 4;
   localparam int         BP     = 2;
   localparam int         PER    = 16;
   localparam logic [2:0] INV    = 3'b100;

   logic       clk_48mhz = 1'b0;
   logic       reset_n   = 1'b0;
   logic       period_start;
   logic [2:0] pwm_out;

   led_pwm_ctrl_if #(.PWM_W(PWM_W)) cfg_bus ();

   led_pwm_ctrl #(
      .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESCALE(0), .BLINK_PERIODS(BP), .OUT_INVERT(INV)
   ) dut (
      .clk_48mhz    (clk_48mhz),
      .reset_n      (reset_n),
      .cfg          (cfg_bus),
      .period_start (period_start),
      .pwm_out      (pwm_out)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   // Clock edges since reset release; after e edges pwm_cnt == e mod 16.
   int ecnt;
   always @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) ecnt <= 0;
      else          ecnt <= ecnt + 1;
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      int ch;
      int ap;
      int mode;
      int duty;
   } wr_t;
   wr_t wlog[$];

   // Level of channel c during period p (period p = pwm window after boundary number p).
   function automatic int exp_eff(int c, int p);
      int m  = 0;
      int d  = 0;
      int ap = 0;
      int k;
      int e;
      foreach (wlog[i]) begin
         if (wlog[i].ch == c && wlog[i].ap <= p) begin
            m  = wlog[i].mode;
            d  = wlog[i].duty;
            ap = wlog[i].ap;
         end
      end
      case (m)
         1: e = d;
         2: e = (((p / BP) % 2) == 0) ? d : 0;
         3: begin
            if (d == 0) e = 0;
            else begin
               k = (p - ap) % (2 * d);
               e = (k <= d) ? k : 2 * d - k;
            end
         end
         default: e = 0;
      endcase
      return e;
   endfunction

   task automatic goto(int e);
      int guard = 0;
      while (ecnt < e && guard < 5000) begin
         @(negedge clk_48mhz);
         guard++;
      end
      checks++;
      if (ecnt != e) begin
         errors++;
         $display("FAIL goto_bound: edge count %0d, required %0d", ecnt, e);
      end
   endtask

   // Accepted at edge k; that write goes live at boundary k/16+1 (a boundary-cycle write waits a period).
   task automatic do_write(int ch, int mode, int duty);
      wr_t w;
      int  k;
      k = ecnt + 1;
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_ch    = 3'(ch);
      cfg_bus.cfg_mode  = 2'(mode);
      cfg_bus.cfg_duty  = 4'(duty);
      @(negedge clk_48mhz);
      cfg_bus.cfg_valid = 1'b0;
      if (ch < NUM_CH) begin
         w.ch = ch; w.ap = k / PER + 1; w.mode = mode; w.duty = duty;
         wlog.push_back(w);
      end
   endtask

   task automatic measure(int p, output int hi[3]);
      logic [2:0] act;
      goto(PER * p);
      hi = '{0, 0, 0};
      repeat (PER) begin
         @(negedge clk_48mhz);
         act = pwm_out ^ INV;
         for (int c = 0; c < NUM_CH; c++) hi[c] += int'(act[c]);
      end
   endtask

   task automatic test_reset();
      int first = -1;
      int second = -1;
      int bad = 0;
      reset_n = 1'b0;
      cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_mode = '0; cfg_bus.cfg_duty = '0;
      repeat (3) @(negedge clk_48mhz);
      checks++; if (pwm_out !== INV) begin errors++; $display("FAIL rst_pwm_out: got %b want %b", pwm_out, INV); end
      checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", cfg_bus.cfg_ready); end
      checks++; if (cfg_bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", cfg_bus.cfg_err); end
      checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_period_start: got %b want 0", period_start); end
      reset_n = 1'b1;
      @(negedge clk_48mhz);
      checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", cfg_bus.cfg_ready); end
      for (int i = 0; i < 40 && second < 0; i++) begin
         if (pwm_out !== INV) bad++;
         if (period_start === 1'b1) begin
            if (first < 0) first = ecnt;
            else           second = ecnt;
         end
         @(negedge clk_48mhz);
      end
      checks++; if (first != PER) begin errors++; $display("FAIL first_period_start: at edge %0d want %0d", first, PER); end
      checks++; if (second - first != PER) begin errors++; $display("FAIL period_start_spacing: got %0d want %0d", second - first, PER); end
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_pwm_out: %0d cycles off the idle level, want 0", bad); end
   endtask

   task automatic test_steady();
      int p;
      int bad = 0;
      int hi[3];
      p = ecnt / PER + 1;
      goto(PER * p + 5);
      do_write(0, 1, 4);
      if (pwm_out[0] !== ((ecnt - 1) % PER < exp_eff(0, p))) bad++;
      while (ecnt < PER * (p + 1)) begin
         @(negedge clk_48mhz);
         if (pwm_out[0] !== ((ecnt - 1) % PER < exp_eff(0, p))) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL steady_before_boundary: %0d wrong cycles, want 0", bad); end
      for (int i = 1; i <= 2; i++) begin
         measure(p + i, hi);
         checks++; if (hi[0] != 4) begin errors++; $display("FAIL steady_count: period %0d got %0d want 4", p + i, hi[0]); end
         checks++; if (hi[0] != exp_eff(0, p + i)) begin errors++; $display("FAIL steady_model: got %0d want %0d", hi[0], exp_eff(0, p + i)); end
      end
   endtask

   task automatic test_blink();
      int p;
      int hi[3];
      p = ecnt / PER + 1;
      goto(PER * p + 2);
      do_write(1, 2, 15);
      for (int i = 1; i <= 6; i++) begin
         measure(p + i, hi);
         for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (hi[c] != exp_eff(c, p + i)) begin
               errors++; $display("FAIL blink ch%0d period %0d: got %0d want %0d", c, p + i, hi[c], exp_eff(c, p + i));
            end
         end
      end
   endtask

   task automatic test_breathe();
      int p;
      int hi[3];
      p = ecnt / PER + 1;
      goto(PER * p + 9);
      do_write(2, 3, 3);
      for (int i = 1; i <= 8; i++) begin
         measure(p + i, hi);
         checks++;
         if (hi[2] != exp_eff(2, p + i)) begin
            errors++; $display("FAIL breathe period %0d: got %0d want %0d", i - 1, hi[2], exp_eff(2, p + i));
         end
      end
   endtask

   task automatic test_back_to_back();
      int p;
      int hi[3];
      p = ecnt / PER + 1;
      goto(PER * p + 3);
      do_write(0, 1, 2);
      goto(PER * p + 5);
      do_write(0, 1, 9);
      goto(PER * (p + 1) - 1);
      do_write(0, 1, 6);
      measure(p + 1, hi);
      checks++; if (hi[0] != 9) begin errors++; $display("FAIL last_write_wins: got %0d want 9", hi[0]); end
      measure(p + 2, hi);
      checks++; if (hi[0] != 6) begin errors++; $display("FAIL boundary_write_delayed: got %0d want 6", hi[0]); end
      checks++; if (hi[2] != exp_eff(2, p + 2)) begin errors++; $display("FAIL b2b_ch2: got %0d want %0d", hi[2], exp_eff(2, p + 2)); end
   endtask

   task automatic test_bad_ch();
      int p;
      int hi[3];
      p = ecnt / PER + 1;
      goto(PER * p + 4);
      do_write(5, 1, 7);
      checks++; if (cfg_bus.cfg_err !== 1'b1) begin errors++; $display("FAIL bad_ch_err: got %b want 1", cfg_bus.cfg_err); end
      checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_ch_ready: got %b want 1", cfg_bus.cfg_ready); end
      @(negedge clk_48mhz);
      checks++; if (cfg_bus.cfg_err !== 1'b0) begin errors++; $display("FAIL bad_ch_err_pulse: got %b want 0", cfg_bus.cfg_err); end
      measure(p + 1, hi);
      for (int c = 0; c < NUM_CH; c++) begin
         checks++;
         if (hi[c] != exp_eff(c, p + 1)) begin
            errors++; $display("FAIL bad_ch_unchanged ch%0d: got %0d want %0d", c, hi[c], exp_eff(c, p + 1));
         end
      end
   endtask

   task automatic test_random();
      int p, ch, mode, duty, off;
      int hi[3];
      for (int r = 0; r < 8; r++) begin
         ch   = $urandom_range(0, 2);
         mode = $urandom_range(0, 3);
         duty = $urandom_range(0, 15);
         off  = $urandom_range(0, 15);
         p = ecnt / PER + 1;
         goto(PER * p + off);
         do_write(ch, mode, duty);
         for (int i = 1; i <= 3; i++) begin
            measure(p + i, hi);
            for (int c = 0; c < NUM_CH; c++) begin
               checks++;
               if (hi[c] != exp_eff(c, p + i)) begin
                  errors++;
                  $display("FAIL random r%0d ch%0d period %0d: got %0d want %0d", r, c, p + i, hi[c], exp_eff(c, p + i));
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int p;
      int hi[3];
      p = ecnt / PER + 1;
      goto(PER * p + 1);
      do_write(0, 1, 15);
      goto(PER * (p + 1) + 7);
      checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_level: got %b want 1", pwm_out[0]); end
      do_write(1, 1, 8);
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (pwm_out !== INV) begin errors++; $display("FAIL async_reset_pwm_out: got %b want %b", pwm_out, INV); end
      checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready: got %b want 0", cfg_bus.cfg_ready); end
      wlog.delete();
      @(negedge clk_48mhz);
      reset_n = 1'b1;
      measure(1, hi);
      for (int c = 0; c < NUM_CH; c++) begin
         checks++;
         if (hi[c] != exp_eff(c, 1)) begin
            errors++; $display("FAIL pending_lost ch%0d: got %0d want %0d", c, hi[c], exp_eff(c, 1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_blink();
      test_breathe();
      test_back_to_back();
      test_bad_ch();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
